// File: rtl/axi_burst_master.sv
// AXI4 INCR burst traffic generator and read checker.
// One command at a time; writes a seeded pattern, verifies it on read.
package axi_pkg;
  localparam int AXI_IW     = 4;
  localparam int AXI_AW     = 32;
  localparam int AXI_DW     = 64;
  localparam int AXI_LW     = 8;
  localparam int AXI_SW     = 3;
  localparam int AXI_BURSTW = 2;
  localparam int AXI_WSTRBW = AXI_DW / 8;
  localparam int AXI_BRESPW = 2;
  localparam int AXI_RRESPW = 2;
endpackage

module axi_burst_master #(
  parameter int AXI_IW     = axi_pkg::AXI_IW,
  parameter int AXI_AW     = axi_pkg::AXI_AW,
  parameter int AXI_DW     = axi_pkg::AXI_DW,
  parameter int AXI_LW     = axi_pkg::AXI_LW,
  parameter int AXI_SW     = axi_pkg::AXI_SW,
  parameter int AXI_BURSTW = axi_pkg::AXI_BURSTW,
  parameter int AXI_WSTRBW = axi_pkg::AXI_WSTRBW,
  parameter int AXI_BRESPW = axi_pkg::AXI_BRESPW,
  parameter int AXI_RRESPW = axi_pkg::AXI_RRESPW,
  parameter logic [AXI_IW-1:0] TG_ID = '0
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [AXI_AW-1:0]     cmd_addr,
  input  logic [AXI_LW-1:0]     cmd_len,
  input  logic [31:0]           cmd_seed,
  output logic                  done,
  output logic [15:0]           err_cnt,
  output logic                  resp_err,
  output logic [AXI_IW-1:0]     AWID,
  output logic [AXI_AW-1:0]     AWADDR,
  output logic [AXI_LW-1:0]     AWLEN,
  output logic [AXI_SW-1:0]     AWSIZE,
  output logic [AXI_BURSTW-1:0] AWBURST,
  output logic                  AWLOCK,
  output logic [3:0]            AWCACHE,
  output logic [2:0]            AWPROT,
  output logic [3:0]            AWQOS,
  output logic [3:0]            AWREGION,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [AXI_DW-1:0]     WDATA,
  output logic [AXI_WSTRBW-1:0] WSTRB,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [AXI_IW-1:0]     BID,
  input  logic [AXI_BRESPW-1:0] BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [AXI_IW-1:0]     ARID,
  output logic [AXI_AW-1:0]     ARADDR,
  output logic [AXI_LW-1:0]     ARLEN,
  output logic [AXI_SW-1:0]     ARSIZE,
  output logic [AXI_BURSTW-1:0] ARBURST,
  output logic                  ARLOCK,
  output logic [3:0]            ARCACHE,
  output logic [2:0]            ARPROT,
  output logic [3:0]            ARQOS,
  output logic [3:0]            ARREGION,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [AXI_IW-1:0]     RID,
  input  logic [AXI_DW-1:0]     RDATA,
  input  logic [AXI_RRESPW-1:0] RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AW   = 3'd1;
  localparam logic [2:0] S_W    = 3'd2;
  localparam logic [2:0] S_B    = 3'd3;
  localparam logic [2:0] S_AR   = 3'd4;
  localparam logic [2:0] S_R    = 3'd5;
  localparam logic [2:0] S_FIN  = 3'd6;

  localparam int LANES = AXI_DW / 32;
  localparam int BSZ   = $clog2(AXI_WSTRBW);

  logic [2:0]            state;
  logic [AXI_LW:0]       beat;
  logic [31:0]           base;
  logic [AXI_AW-1:0]     addr_q;
  logic [AXI_LW-1:0]     len_q;
  logic [AXI_SW-1:0]     size_q;
  logic [AXI_BURSTW-1:0] burst_q;
  logic [AXI_DW-1:0]     wdata_q;
  logic [AXI_WSTRBW-1:0] wstrb_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  wlast_q;
  logic                  bready_q;
  logic                  arvalid_q;
  logic                  rready_q;
  logic                  cmd_ready_q;
  logic                  done_q;
  logic [15:0]           err_q;
  logic                  rerr_q;

  logic [31:0] base_nx;
  logic        last_beat;
  logic        r_bad;

  function automatic logic [AXI_DW-1:0] pat(
    input logic [31:0] b
  );
    logic [AXI_DW-1:0] v;
    v = '0;
    for (int j = 0; j < LANES; j++)
      v[j*32 +: 32] = b + 32'(j);
    return v;
  endfunction

  assign base_nx   = base + 32'(LANES);
  assign last_beat = (beat == {1'b0, len_q});
  assign r_bad     = (RDATA != pat(base))
                  || (RID != TG_ID)
                  || (RLAST != last_beat);

  // Burst sequencing, pattern generation and read checking.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state       <= S_IDLE;
      beat        <= '0;
      base        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= '0;
      rerr_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            addr_q  <= cmd_addr
                     & ~AXI_AW'(AXI_WSTRBW - 1);
            len_q   <= cmd_len;
            size_q  <= AXI_SW'(BSZ);
            burst_q <= AXI_BURSTW'(1);
            base    <= cmd_seed;
            beat    <= '0;
            if (cmd_write) begin
              awvalid_q <= 1'b1;
              state     <= S_AW;
            end else begin
              arvalid_q <= 1'b1;
              state     <= S_AR;
            end
          end
        end
        S_AW: if (AWREADY) begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b1;
          wdata_q   <= pat(base);
          wstrb_q   <= '1;
          wlast_q   <= (len_q == '0);
          state     <= S_W;
        end
        S_W: if (WREADY) begin
          if (last_beat) begin
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
            bready_q <= 1'b1;
            state    <= S_B;
          end else begin
            beat    <= beat + 1'b1;
            base    <= base_nx;
            wdata_q <= pat(base_nx);
            wlast_q <= ((beat + 1'b1)
                       == {1'b0, len_q});
          end
        end
        S_B: if (BVALID) begin
          bready_q <= 1'b0;
          done_q   <= 1'b1;
          state    <= S_FIN;
          if (BRESP != '0 || BID != TG_ID)
            rerr_q <= 1'b1;
        end
        S_AR: if (ARREADY) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state     <= S_R;
        end
        S_R: if (RVALID) begin
          if (r_bad && err_q != 16'hFFFF)
            err_q <= err_q + 16'd1;
          if (RRESP != '0)
            rerr_q <= 1'b1;
          if (last_beat) begin
            rready_q <= 1'b0;
            done_q   <= 1'b1;
            state    <= S_FIN;
          end else begin
            beat <= beat + 1'b1;
            base <= base_nx;
          end
        end
        S_FIN: begin
          cmd_ready_q <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign done      = done_q;
  assign err_cnt   = err_q;
  assign resp_err  = rerr_q;

  assign AWID     = TG_ID;
  assign AWADDR   = addr_q;
  assign AWLEN    = len_q;
  assign AWSIZE   = size_q;
  assign AWBURST  = burst_q;
  assign AWLOCK   = 1'b0;
  assign AWCACHE  = 4'b0011;
  assign AWPROT   = 3'b000;
  assign AWQOS    = 4'b0000;
  assign AWREGION = 4'b0000;
  assign AWVALID  = awvalid_q;

  assign WDATA  = wdata_q;
  assign WSTRB  = wstrb_q;
  assign WLAST  = wlast_q;
  assign WVALID = wvalid_q;
  assign BREADY = bready_q;

  assign ARID     = TG_ID;
  assign ARADDR   = addr_q;
  assign ARLEN    = len_q;
  assign ARSIZE   = size_q;
  assign ARBURST  = burst_q;
  assign ARLOCK   = 1'b0;
  assign ARCACHE  = 4'b0011;
  assign ARPROT   = 3'b000;
  assign ARQOS    = 4'b0000;
  assign ARREGION = 4'b0000;
  assign ARVALID  = arvalid_q;
  assign RREADY   = rready_q;

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: behavioural AXI slave with memory,
// pattern model computed from seed arithmetic, directed steps.
module tb_axi_burst_master;
  import axi_pkg::*;

  localparam logic [AXI_IW-1:0] TG = 4'h5;
  localparam int LANES = AXI_DW / 32;

  logic                  ACLK;
  logic                  ARESETn;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [AXI_AW-1:0]     cmd_addr;
  logic [AXI_LW-1:0]     cmd_len;
  logic [31:0]           cmd_seed;
  logic                  done;
  logic [15:0]           err_cnt;
  logic                  resp_err;
  logic [AXI_IW-1:0]     AWID, ARID, BID, RID;
  logic [AXI_AW-1:0]     AWADDR, ARADDR;
  logic [AXI_LW-1:0]     AWLEN, ARLEN;
  logic [AXI_SW-1:0]     AWSIZE, ARSIZE;
  logic [AXI_BURSTW-1:0] AWBURST, ARBURST;
  logic                  AWLOCK, ARLOCK;
  logic [3:0]            AWCACHE, ARCACHE;
  logic [2:0]            AWPROT, ARPROT;
  logic [3:0]            AWQOS, ARQOS;
  logic [3:0]            AWREGION, ARREGION;
  logic                  AWVALID, AWREADY;
  logic [AXI_DW-1:0]     WDATA, RDATA;
  logic [AXI_WSTRBW-1:0] WSTRB;
  logic                  WLAST, WVALID, WREADY;
  logic [AXI_BRESPW-1:0] BRESP;
  logic                  BVALID, BREADY;
  logic                  ARVALID, ARREADY;
  logic [AXI_RRESPW-1:0] RRESP;
  logic                  RLAST, RVALID, RREADY;

  axi_burst_master #(.TG_ID(TG)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_seed(cmd_seed),
    .done(done), .err_cnt(err_cnt), .resp_err(resp_err),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWLOCK(AWLOCK),
    .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWQOS(AWQOS),
    .AWREGION(AWREGION), .AWVALID(AWVALID),
    .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID),
    .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARLOCK(ARLOCK),
    .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARQOS(ARQOS),
    .ARREGION(ARREGION), .ARVALID(ARVALID),
    .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP),
    .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  int n_chk, n_pass, n_fail;
  int exp_err;
  logic exp_resp;

  bit bp, stall_w;
  int rmode;
  logic [AXI_BRESPW-1:0] bresp_mode;

  logic [AXI_DW-1:0] mem [int];
  logic [AXI_DW-1:0] wq [$];
  logic              lq [$];
  int rcount, viol, strb_bad, done_cnt;

  logic [AXI_AW-1:0]     s_awaddr, s_araddr, p_awaddr;
  logic [AXI_LW-1:0]     s_awlen, s_arlen;
  logic [AXI_SW-1:0]     s_awsize, s_arsize;
  logic [AXI_BURSTW-1:0] s_awburst, s_arburst;
  logic [AXI_IW-1:0]     s_awid, s_arid;
  logic [3:0]            s_awcache;
  logic [AXI_DW-1:0]     p_wdata;
  logic                  p_wlast;
  bit w_open, b_pend, bfire, r_active, rfire;
  bit p_wstall, p_awstall;
  int wi, ri, idx;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [AXI_DW-1:0] exp_beat(
    input logic [31:0] seed, input int k);
    logic [AXI_DW-1:0] v;
    for (int j = 0; j < LANES; j++)
      v[j*32 +: 32] = seed + 32'(k * LANES + j);
    return v;
  endfunction

  function automatic logic rbit();
    return ($urandom_range(0, 1) == 1);
  endfunction

  // Behavioural slave: all decisions at negedge, handshakes
  // complete at the following posedge.
  initial begin
    AWREADY = 0; WREADY = 0; BVALID = 0; BID = '0;
    BRESP = '0; ARREADY = 0; RVALID = 0; RID = '0;
    RDATA = '0; RRESP = '0; RLAST = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        AWREADY = 0; WREADY = 0; BVALID = 0;
        ARREADY = 0; RVALID = 0; RLAST = 0;
        w_open = 0; b_pend = 0; bfire = 0;
        r_active = 0; rfire = 0;
        p_wstall = 0; p_awstall = 0;
        continue;
      end
      if (done) done_cnt++;
      if (p_wstall && (!WVALID || WDATA !== p_wdata
          || WLAST !== p_wlast)) viol++;
      if (p_awstall && (!AWVALID
          || AWADDR !== p_awaddr)) viol++;
      if (WVALID && !w_open) viol++;
      if (bfire) BVALID = 0;
      if (b_pend) begin
        BVALID = 1; BRESP = bresp_mode;
        BID = TG; b_pend = 0;
      end
      bfire = BVALID && BREADY;
      if (rfire) begin
        ri++; RVALID = 0; RLAST = 0;
      end
      if (r_active && !RVALID) begin
        if (ri > int'(s_arlen)) r_active = 0;
        else if (!bp || rbit()) begin
          idx = int'(s_araddr >> 3) + ri;
          RVALID = 1; RRESP = '0;
          RID = (rmode == 1 && ri == 0) ? ~TG : TG;
          RLAST = (ri == int'(s_arlen)) && (rmode != 2);
          RDATA = mem.exists(idx) ? mem[idx] : '0;
        end
      end
      rfire = RVALID && RREADY;
      if (rfire) rcount++;
      AWREADY = bp ? rbit() : 1'b1;
      p_awstall = AWVALID && !AWREADY;
      p_awaddr = AWADDR;
      if (AWVALID && AWREADY) begin
        s_awaddr = AWADDR; s_awlen = AWLEN;
        s_awsize = AWSIZE; s_awburst = AWBURST;
        s_awid = AWID; s_awcache = AWCACHE;
        w_open = 1; wi = 0;
      end
      WREADY = stall_w ? 1'b0 : bp ? rbit() : 1'b1;
      p_wstall = WVALID && !WREADY;
      p_wdata = WDATA; p_wlast = WLAST;
      if (WVALID && WREADY) begin
        wq.push_back(WDATA); lq.push_back(WLAST);
        if (WSTRB !== '1) strb_bad++;
        mem[int'(s_awaddr >> 3) + wi] = WDATA;
        wi++;
        if (wi == int'(s_awlen) + 1) begin
          w_open = 0; b_pend = 1;
        end
      end
      ARREADY = bp ? rbit() : 1'b1;
      if (ARVALID && ARREADY) begin
        s_araddr = ARADDR; s_arlen = ARLEN;
        s_arsize = ARSIZE; s_arburst = ARBURST;
        s_arid = ARID;
        r_active = 1; ri = 0;
      end
    end
  end

  task automatic run_cmd(input bit wr,
                         input logic [31:0] addr,
                         input int len,
                         input logic [31:0] seed);
    int t, d0;
    wq.delete(); lq.delete(); rcount = 0;
    t = 0;
    while (!cmd_ready && t < 100) begin
      @(negedge ACLK); t++;
    end
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr;
    cmd_len = AXI_LW'(len); cmd_seed = seed;
    d0 = done_cnt;
    @(negedge ACLK);
    cmd_valid = 0;
    chk("cmd_ready_low_after_accept", cmd_ready, 0);
    chk("addr_valid_n_plus_1",
        wr ? AWVALID : ARVALID, 1);
    t = 0;
    while (!done && t < 20000) begin
      @(negedge ACLK); t++;
    end
    chk("done_seen", done, 1);
    @(negedge ACLK);
    chk("done_one_cycle", done, 0);
    chk("cmd_ready_q_plus_2", cmd_ready, 1);
    chk("done_pulses", done_cnt - d0, 1);
  endtask

  task automatic check_write(input logic [31:0] addr,
                             input int len,
                             input logic [31:0] seed);
    int bad, nlast;
    bad = 0; nlast = 0;
    chk("w_beats", wq.size(), len + 1);
    foreach (wq[k]) begin
      if (wq[k] !== exp_beat(seed, k)) bad++;
      if (lq[k]) nlast++;
    end
    chk("w_data_bad_beats", bad, 0);
    chk("wlast_count", nlast, 1);
    chk("wlast_on_final",
        (lq.size() > len) && lq[len], 1);
    chk("aw_addr", s_awaddr, addr & 32'hFFFF_FFF8);
    chk("aw_len", s_awlen, len);
    chk("aw_size", s_awsize, 3);
    chk("aw_burst", s_awburst, 1);
    chk("aw_id", s_awid, TG);
    chk("aw_cache", s_awcache, 4'b0011);
    chk("wstrb_bad", strb_bad, 0);
    chk("protocol_viol", viol, 0);
  endtask

  task automatic check_read(input logic [31:0] addr,
                            input int len);
    chk("r_beats", rcount, len + 1);
    chk("ar_addr", s_araddr, addr & 32'hFFFF_FFF8);
    chk("ar_len", s_arlen, len);
    chk("ar_size", s_arsize, 3);
    chk("ar_burst", s_arburst, 1);
    chk("ar_id", s_arid, TG);
    chk("err_cnt", err_cnt, exp_err);
    chk("resp_err", resp_err, exp_resp);
  endtask

  initial begin
    logic [31:0] seed, addr;
    logic [AXI_DW-1:0] tmpw;
    int t, d0;
    n_chk = 0; n_pass = 0; n_fail = 0;
    bp = 0; stall_w = 0; rmode = 0; bresp_mode = '0;
    rcount = 0; viol = 0; strb_bad = 0; done_cnt = 0;
    exp_err = 0; exp_resp = 0;
    cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    cmd_seed = '0;

    ARESETn = 0; cmd_valid = 1;
    repeat (3) begin
      @(negedge ACLK);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_valids",
          {AWVALID, WVALID, ARVALID, BREADY, RREADY}, 0);
      chk("rst_fields", {AWADDR, AWLEN, WDATA}, 0);
    end
    chk("rst_err", {err_cnt, resp_err, done}, 0);
    cmd_valid = 0; ARESETn = 1;
    @(negedge ACLK);
    chk("cmd_ready_after_release", cmd_ready, 1);

    run_cmd(1, 32'h100, 3, 32'h1000);
    check_write(32'h100, 3, 32'h1000);
    chk("beat1_lane0", wq.size() > 1 ? wq[1][31:0] : 0,
        32'h1000 + LANES);
    run_cmd(0, 32'h100, 3, 32'h1000);
    check_read(32'h100, 3);
    chk("two_done_pulses", done_cnt, 2);

    tmpw = mem[32'h100 >> 3];
    tmpw[7:0] = ~tmpw[7:0];
    mem[32'h100 >> 3] = tmpw;
    exp_err = 1;
    run_cmd(0, 32'h100, 3, 32'h1000);
    check_read(32'h100, 3);

    rmode = 1; exp_err = 2;
    run_cmd(0, 32'h100, 3, 32'h1000);
    check_read(32'h100, 3);
    rmode = 2; exp_err = 4;
    run_cmd(0, 32'h100, 3, 32'h1000);
    check_read(32'h100, 3);
    rmode = 0;

    bp = 1;
    for (int i = 0; i < 3; i++) begin
      seed = $urandom;
      addr = 32'h2000 + 32'($urandom_range(0, 15)) * 128
           + 32'($urandom_range(0, 7));
      run_cmd(1, addr, 15, seed);
      check_write(addr, 15, seed);
      run_cmd(0, addr, 15, seed);
      check_read(addr, 15);
    end
    bp = 0;

    seed = $urandom;
    run_cmd(1, 32'h4000, 255, seed);
    check_write(32'h4000, 255, seed);
    run_cmd(0, 32'h4000, 255, seed);
    check_read(32'h4000, 255);

    bresp_mode = 2'b10;
    run_cmd(1, 32'h3000, 0, 32'hABCD_0000);
    check_write(32'h3000, 0, 32'hABCD_0000);
    exp_resp = 1;
    chk("resp_err_set", resp_err, 1);
    bresp_mode = 2'b00;
    seed = $urandom;
    run_cmd(1, 32'h3100, 3, seed);
    check_write(32'h3100, 3, seed);
    run_cmd(0, 32'h3100, 3, seed);
    check_read(32'h3100, 3);

    stall_w = 1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h5000;
    cmd_len = 8'd15; cmd_seed = 32'h77;
    @(negedge ACLK);
    cmd_valid = 0;
    t = 0;
    while (!WVALID && t < 50) begin
      @(negedge ACLK); t++;
    end
    chk("mid_wvalid_up", WVALID, 1);
    d0 = done_cnt;
    ARESETn = 0;
    @(negedge ACLK);
    chk("mid_rst_valids",
        {AWVALID, WVALID, WLAST, BREADY, ARVALID}, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    @(negedge ACLK);
    ARESETn = 1; stall_w = 0;
    @(negedge ACLK);
    chk("mid_cmd_ready", cmd_ready, 1);
    chk("mid_err_clear", {err_cnt, resp_err}, 0);
    repeat (3) @(negedge ACLK);
    chk("mid_no_done", done_cnt - d0, 0);
    chk("mid_idle_valids", {AWVALID, WVALID}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
